// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command-decoding controller: opcodes, FSM states
// and the fixed register-file slots used for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_RD,
    OP_A,
    OP_B,
    FUNC,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// Command decoder between the UART RX byte stream, the register file, the ALU
// and the TX FIFO. All outputs are registered; the current state is exported on dbg_state.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    ALU_EN,
  output logic [FUNC_WIDTH-1:0]   ALU_FUNC,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    CMD_DROP,
  output state_e                  dbg_state
);

  // Handshakes: RX_D_VLD, RF_RD_DATA_VLD and ALU_OUT_VLD are single-cycle valids
  // with no back-pressure. FIFO_FULL is the TX ready (low = ready); TX_D_VLD is
  // raised only for a cycle whose preceding edge sampled FIFO_FULL low.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data, rd_data_d;
  logic [2*DATA_WIDTH-1:0] alu_res, alu_res_d;

  logic [ADDR_WIDTH-1:0]   rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d, tx_data_d;
  logic [FUNC_WIDTH-1:0]   alu_func_d;
  logic                    rf_wr_en_d, rf_rd_en_d, alu_en_d, clk_en_d;
  logic                    tx_vld_d, cmd_drop_d;
  logic                    expired;

  assign dbg_state = state;
  assign expired   = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_data    <= '0;
      alu_res    <= '0;
      RF_ADDR    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUNC   <= '0;
      CLK_EN     <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      CMD_DROP   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      rd_data    <= rd_data_d;
      alu_res    <= alu_res_d;
      RF_ADDR    <= rf_addr_d;
      RF_WR_EN   <= rf_wr_en_d;
      RF_RD_EN   <= rf_rd_en_d;
      RF_WR_DATA <= rf_wr_data_d;
      ALU_EN     <= alu_en_d;
      ALU_FUNC   <= alu_func_d;
      CLK_EN     <= clk_en_d;
      TX_P_DATA  <= tx_data_d;
      TX_D_VLD   <= tx_vld_d;
      CMD_DROP   <= cmd_drop_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    rd_data_d    = rd_data;
    alu_res_d    = alu_res;
    rf_addr_d    = RF_ADDR;
    rf_wr_data_d = RF_WR_DATA;
    alu_func_d   = ALU_FUNC;
    clk_en_d     = CLK_EN;
    tx_data_d    = TX_P_DATA;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_vld_d     = 1'b0;
    cmd_drop_d   = 1'b0;

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))        state_d = WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))   state_d = RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = OP_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = FUNC;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          cnt_d      = '0;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cmd_drop_d = RX_D_VLD;
        cnt_d      = cnt + 1'b1;
        // A valid on the terminal-count cycle takes priority over the abort.
        if (RF_RD_DATA_VLD) begin
          rd_data_d = RF_RD_DATA;
          state_d   = TX_RD;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      TX_RD: begin
        cmd_drop_d = RX_D_VLD;
        if (!FIFO_FULL) begin
          tx_data_d = rd_data;
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = FUNC;
        end
      end
      FUNC: begin
        if (RX_D_VLD) begin
          alu_func_d = RX_P_DATA[FUNC_WIDTH-1:0];
          alu_en_d   = 1'b1;
          clk_en_d   = 1'b1;
          cnt_d      = '0;
          state_d    = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        cmd_drop_d = RX_D_VLD;
        cnt_d      = cnt + 1'b1;
        if (ALU_OUT_VLD) begin
          alu_res_d = ALU_OUT;
          clk_en_d  = 1'b0;
          state_d   = TX_LO;
        end else if (expired) begin
          clk_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      TX_LO: begin
        cmd_drop_d = RX_D_VLD;
        if (!FIFO_FULL) begin
          tx_data_d = alu_res[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = TX_HI;
        end
      end
      TX_HI: begin
        cmd_drop_d = RX_D_VLD;
        if (!FIFO_FULL) begin
          tx_data_d = alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command-decoding controller in the REF_CLK domain.
- Consumes synchronized UART RX bytes (DATA_SYNC sync_bus / enable_pulse).
- Drives the register file (address, write/read strobes), the ALU (enable, function, clock-gate enable) and the TX FIFO write port (data, W_INC).
- Closes the loop between the UART receiver and the UART transmitter in SYS_TOP.

Parameters:
- DATA_WIDTH, 8, width of RX/TX bytes and register-file words.
- ADDR_WIDTH, 4, register-file address width; the address is taken from RX byte bits [ADDR_WIDTH-1:0].
- FUNC_WIDTH, 4, ALU function code width; taken from RX byte bits [FUNC_WIDTH-1:0].
- TIMEOUT, 255, maximum cycles spent waiting for RF_RD_DATA_VLD or ALU_OUT_VLD before aborting to IDLE.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  synchronized received byte.
- RX_D_VLD  in  1  single-cycle pulse; RX_P_DATA is valid.
- RF_RD_DATA  in  DATA_WIDTH  register-file read data.
- RF_RD_DATA_VLD  in  1  read data valid pulse.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid pulse.
- FIFO_FULL  in  1  TX FIFO full flag.
- RF_ADDR  out  ADDR_WIDTH  register-file address.
- RF_WR_EN  out  1  write strobe.
- RF_RD_EN  out  1  read strobe.
- RF_WR_DATA  out  DATA_WIDTH  write data.
- ALU_EN  out  1  ALU operation strobe.
- ALU_FUNC  out  FUNC_WIDTH  ALU function code.
- CLK_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  byte to the TX FIFO.
- TX_D_VLD  out  1  FIFO W_INC strobe.
- CMD_DROP  out  1  pulse: byte discarded.

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, timeout counter 0.
- Strobes (RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CMD_DROP) are exactly one cycle wide. Each is asserted in the cycle after the triggering input is sampled.
- Command opcodes: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands.
- Any other byte in IDLE is ignored silently: no strobe, no CMD_DROP.
- FSM states and transitions:
  - IDLE --AA--> WR_ADDR --byte--> WR_DATA --byte--> IDLE. RF_WR_EN is pulsed with the latched address and the data byte.
  - IDLE --BB--> RD_ADDR --byte--> RD_WAIT. RF_RD_EN is pulsed on entry. On RF_RD_DATA_VLD the data is latched and the FSM moves to TX_RD. In TX_RD, when FIFO_FULL=0, TX_D_VLD is pulsed with the data, then IDLE.
  - IDLE --CC--> OP_A --byte--> OP_B --byte--> FUNC. Operand A is written to RF address 0 and operand B to RF address 1, each with an RF_WR_EN pulse.
  - IDLE --DD--> FUNC. Operands already in the register file are used.
  - In FUNC, on a byte: ALU_EN is pulsed with ALU_FUNC=byte[FUNC_WIDTH-1:0], CLK_EN rises in the same cycle, and the FSM moves to ALU_WAIT.
  - In ALU_WAIT, on ALU_OUT_VLD the 16-bit result is latched, CLK_EN falls next cycle, and the FSM moves to TX_LO.
  - TX_LO sends the low byte, then TX_HI sends the high byte, then IDLE. Each byte is sent only when FIFO_FULL=0.
- ALU_FUNC and RF_ADDR hold their last value between operations.
- FIFO_FULL=1 stalls the TX states indefinitely; no byte is lost or duplicated. TX_D_VLD is never asserted while FIFO_FULL=1 is sampled.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state: the byte is discarded, CMD_DROP is pulsed, and the state is unchanged.
- Timeout:
  - The counter clears on entry to RD_WAIT or ALU_WAIT.
  - If it reaches TIMEOUT without the corresponding valid, the FSM goes to IDLE, CLK_EN goes to 0, and nothing is sent.
  - A valid arriving in the same cycle as the terminal count wins over the timeout.
- RST asserted mid-command: immediate return to IDLE with all outputs 0. A partially received command is discarded, and no register-file write occurs after reset.

Decomposition:
- Shared package sys_ctrl_pkg:
  - opcode constants CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP;
  - state enum;
  - operand addresses OPA_ADDR=0, OPB_ADDR=1.
- The FSM, datapath latches and timeout counter stay in one module; no sub-module is needed.

Test Plan:
- RX bytes AA,05,3C -> one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C; no TX_D_VLD.
- RX BB,05; RF model returns 0x3C two cycles after RF_RD_EN -> exactly one TX_D_VLD with TX_P_DATA=0x3C.
- RX CC,0A,03,00 (ADD); ALU returns 0x000D -> RF writes (0,0x0A) and (1,0x03); ALU_EN with FUNC=0; CLK_EN high until ALU_OUT_VLD; TX bytes 0x0D then 0x00.
- RX DD,02 (MUL) with ALU_OUT=0x1234 and FIFO_FULL held high for 10 cycles -> no TX_D_VLD while full; then 0x34 and 0x12 sent once each.
- RX 55 in IDLE, then BB,02 with no RF_RD_DATA_VLD -> 55 ignored; timeout after 255 cycles returns to IDLE with no TX; an extra byte sent during RD_WAIT produces a CMD_DROP pulse.
- RST pulsed after AA,07 -> all outputs 0; a following 0x11 is ignored and no RF_WR_EN occurs.
